// File: rtl/gpio_bank_pkg.sv
// Shared constants for the GPIO bank: register offsets within a channel window,
// the channel stride and a constant-evaluable ceil(log2) helper.
package gpio_bank_pkg;

   localparam logic [4:0] OFS_IN      = 5'h00;
   localparam logic [4:0] OFS_OUT     = 5'h04;
   localparam logic [4:0] OFS_RISE_EN = 5'h08;
   localparam logic [4:0] OFS_FALL_EN = 5'h0C;
   localparam logic [4:0] OFS_STATUS  = 5'h10;

   localparam int CH_STRIDE = 'h20;

   function automatic int clog2(input int value);
      int result;
      int v;
      result = 0;
      v      = value - 1;
      while (v > 0) begin
         result = result + 1;
         v      = v >> 1;
      end
      return result;
   endfunction

   // Low address bits select the register inside a channel window.
   localparam int CH_SHIFT = clog2(CH_STRIDE);

endpackage

// File: rtl/gpio_debounce.sv
// One channel's input path: two-flop synchroniser, optional per-bit debounce
// filter, and rise/fall detection on the filtered value.
module gpio_debounce
   import gpio_bank_pkg::*;
#(
   parameter int W          = 8,
   parameter int DEB_CYCLES = 0
) (
   input  logic         clk,
   input  logic         resetb,
   input  logic [W-1:0] din,
   output logic [W-1:0] filtered,
   output logic [W-1:0] rise,
   output logic [W-1:0] fall
);

   localparam int CNT_W = (DEB_CYCLES > 0) ? clog2(DEB_CYCLES + 1) : 1;

   logic [W-1:0] sync1_reg;
   logic [W-1:0] sync2_reg;
   logic [W-1:0] prev_reg;

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         sync1_reg <= '0;
         sync2_reg <= '0;
         prev_reg  <= '0;
      end else begin
         sync1_reg <= din;
         sync2_reg <= sync1_reg;
         prev_reg  <= filtered;
      end
   end

   generate
      if (DEB_CYCLES == 0) begin : g_bypass
         assign filtered = sync2_reg;
      end else begin : g_filter
         for (genvar gi = 0; gi < W; gi++) begin : g_bit
            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W-1:0] cnt_next;
            logic             filt_reg;
            logic             filt_next;

            // The counter only runs while the synchronised bit disagrees with
            // the filtered bit; any agreement restarts the stability window.
            always_comb begin
               cnt_next  = '0;
               filt_next = filt_reg;
               if (sync2_reg[gi] != filt_reg) begin
                  if (cnt_reg == CNT_W'(DEB_CYCLES - 1)) begin
                     filt_next = sync2_reg[gi];
                  end else begin
                     cnt_next = cnt_reg + 1'b1;
                  end
               end
            end

            always_ff @(posedge clk or negedge resetb) begin
               if (!resetb) begin
                  cnt_reg  <= '0;
                  filt_reg <= 1'b0;
               end else begin
                  cnt_reg  <= cnt_next;
                  filt_reg <= filt_next;
               end
            end

            assign filtered[gi] = filt_reg;
         end
      end
   endgenerate

   assign rise = filtered & ~prev_reg;
   assign fall = ~filtered & prev_reg;

endmodule

// File: rtl/gpio_bank_ctrl.sv
// Multi-channel GPIO peripheral on the MCS IO bus: per-channel output, edge
// enables and W1C status registers, with one registered combined interrupt.
module gpio_bank_ctrl
   import gpio_bank_pkg::*;
#(
   parameter int NCH        = 2,
   parameter int W          = 8,
   parameter int DEB_CYCLES = 0,
   parameter int ADDR_W     = 8
) (
   input  logic              clk,
   input  logic              resetb,
   input  logic [ADDR_W-1:0] io_addr,
   input  logic              io_wr,
   input  logic              io_rd,
   input  logic [31:0]       io_wdata,
   output logic [31:0]       io_rdata,
   output logic              io_ready,
   input  logic [NCH*W-1:0]  gpio_i,
   output logic [NCH*W-1:0]  gpio_o,
   output logic              irq
);

   localparam int CH_W = ADDR_W - CH_SHIFT;

   logic [4:0]            ofs;
   logic [W-1:0]          wdata_w;
   logic [NCH-1:0]        ch_irq;
   logic [NCH-1:0][31:0]  ch_rdata;
   logic [31:0]           rd_mux;

   logic [31:0]           io_rdata_reg;
   logic [31:0]           io_rdata_next;
   logic                  io_ready_reg;
   logic                  irq_reg;

   assign ofs     = io_addr[CH_SHIFT-1:0];
   assign wdata_w = io_wdata[W-1:0];

   generate
      if (W < 32) begin : g_wdata_upper
         logic unused_wdata;
         assign unused_wdata = ^io_wdata[31:W];
      end
   endgenerate

   generate
      for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
         logic [W-1:0] filt;
         logic [W-1:0] rise;
         logic [W-1:0] fall;
         logic [W-1:0] out_reg;
         logic [W-1:0] rise_en_reg;
         logic [W-1:0] fall_en_reg;
         logic [W-1:0] status_reg;
         logic [W-1:0] status_next;
         logic [W-1:0] set_bits;
         logic [W-1:0] w1c;
         logic         sel;
         logic [31:0]  rd_val;

         // Channel indices at or beyond NCH never match, so those windows
         // fall through to the unmapped behaviour.
         assign sel = (io_addr[ADDR_W-1:CH_SHIFT] == CH_W'(gi));

         gpio_debounce #(
            .W          (W),
            .DEB_CYCLES (DEB_CYCLES)
         ) u_debounce (
            .clk      (clk),
            .resetb   (resetb),
            .din      (gpio_i[gi*W +: W]),
            .filtered (filt),
            .rise     (rise),
            .fall     (fall)
         );

         assign set_bits = (rise & rise_en_reg) | (fall & fall_en_reg);
         assign w1c      = (io_wr && sel && (ofs == OFS_STATUS)) ? wdata_w : '0;
         // A new edge outranks a simultaneous clear of the same bit.
         assign status_next = (status_reg & ~w1c) | set_bits;

         always_ff @(posedge clk or negedge resetb) begin
            if (!resetb) begin
               out_reg     <= '0;
               rise_en_reg <= '0;
               fall_en_reg <= '0;
               status_reg  <= '0;
            end else begin
               if (io_wr && sel) begin
                  case (ofs)
                     OFS_OUT:     out_reg     <= wdata_w;
                     OFS_RISE_EN: rise_en_reg <= wdata_w;
                     OFS_FALL_EN: fall_en_reg <= wdata_w;
                     default: ;
                  endcase
               end
               status_reg <= status_next;
            end
         end

         always_comb begin
            rd_val = '0;
            if (sel) begin
               case (ofs)
                  OFS_IN:      rd_val = 32'(filt);
                  OFS_OUT:     rd_val = 32'(out_reg);
                  OFS_RISE_EN: rd_val = 32'(rise_en_reg);
                  OFS_FALL_EN: rd_val = 32'(fall_en_reg);
                  OFS_STATUS:  rd_val = 32'(status_reg);
                  default:     rd_val = '0;
               endcase
            end
         end

         assign ch_rdata[gi]       = rd_val;
         assign ch_irq[gi]         = |(status_reg & (rise_en_reg | fall_en_reg));
         assign gpio_o[gi*W +: W]  = out_reg;
      end
   endgenerate

   // At most one channel is selected, so OR-ing the per-channel values is a mux.
   always_comb begin
      rd_mux = '0;
      for (int c = 0; c < NCH; c++) begin
         rd_mux = rd_mux | ch_rdata[c];
      end
   end

   assign io_rdata_next = io_rd ? rd_mux : 32'h0;

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         io_rdata_reg <= '0;
         io_ready_reg <= 1'b0;
         irq_reg      <= 1'b0;
      end else begin
         io_rdata_reg <= io_rdata_next;
         io_ready_reg <= io_wr | io_rd;
         irq_reg      <= |ch_irq;
      end
   end

   assign io_rdata = io_rdata_reg;
   assign io_ready = io_ready_reg;
   assign irq      = irq_reg;

endmodule

// File: tb/tb_gpio_bank_ctrl.sv
// Self-checking bench for gpio_bank_ctrl: a bypass instance (DEB_CYCLES=0) and a
// debounced instance (DEB_CYCLES=4) share the bus; bus_sel picks the target.
module tb_gpio_bank_ctrl;

   localparam int NCH = 2;
   localparam int W   = 8;

   logic        clk      = 1'b0;
   logic        resetb   = 1'b0;
   logic [7:0]  io_addr  = '0;
   logic        io_wr    = 1'b0;
   logic        io_rd    = 1'b0;
   logic        bus_sel  = 1'b0;
   logic [31:0] io_wdata = '0;
   logic [15:0] gpio_i0  = '0;
   logic [15:0] gpio_i1  = '0;

   logic        wr0, rd0, wr1, rd1;
   logic [31:0] rdata0, rdata1;
   logic        ready0, ready1, irq0, irq1;
   logic [15:0] gpio_o0, gpio_o1;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference state for the bypass instance, kept at register level.
   logic [7:0]  m_out  [NCH];
   logic [7:0]  m_ren  [NCH];
   logic [7:0]  m_fen  [NCH];
   logic [7:0]  m_stat [NCH];
   logic [15:0] m_in;

   always #5 clk = ~clk;

   assign wr0 = io_wr & ~bus_sel;
   assign rd0 = io_rd & ~bus_sel;
   assign wr1 = io_wr & bus_sel;
   assign rd1 = io_rd & bus_sel;

   gpio_bank_ctrl #(.NCH(NCH), .W(W), .DEB_CYCLES(0), .ADDR_W(8)) dut (
      .clk(clk), .resetb(resetb), .io_addr(io_addr), .io_wr(wr0), .io_rd(rd0),
      .io_wdata(io_wdata), .io_rdata(rdata0), .io_ready(ready0),
      .gpio_i(gpio_i0), .gpio_o(gpio_o0), .irq(irq0)
   );

   gpio_bank_ctrl #(.NCH(NCH), .W(W), .DEB_CYCLES(4), .ADDR_W(8)) dut_deb (
      .clk(clk), .resetb(resetb), .io_addr(io_addr), .io_wr(wr1), .io_rd(rd1),
      .io_wdata(io_wdata), .io_rdata(rdata1), .io_ready(ready1),
      .gpio_i(gpio_i1), .gpio_o(gpio_o1), .irq(irq1)
   );

   function automatic logic [7:0] ra(input int ch, input int ofs);
      return 8'(ch * 32 + ofs);
   endfunction

   function automatic logic m_irq();
      logic r;
      r = 1'b0;
      for (int c = 0; c < NCH; c++) r = r | (|(m_stat[c] & (m_ren[c] | m_fen[c])));
      return r;
   endfunction

   // Called at a negedge; the strobe is seen at the next posedge and the
   // acknowledge is sampled at the negedge after it.
   task automatic bus_xfer(input logic [7:0] a, input logic wr, input logic rd,
                           input logic [31:0] d, output logic [31:0] q, output logic rdy);
      io_addr  = a;
      io_wdata = d;
      io_wr    = wr;
      io_rd    = rd;
      @(negedge clk);
      io_wr = 1'b0;
      io_rd = 1'b0;
      q   = bus_sel ? rdata1 : rdata0;
      rdy = bus_sel ? ready1 : ready0;
      $display("xfer dut%0d addr=%h wr=%b rd=%b wdata=%h rdata=%h ready=%b",
               bus_sel, a, wr, rd, d, q, rdy);
   endtask

   task automatic test_reset();
      logic [31:0] q;
      logic        rdy;
      logic [31:0] exp;
      for (int c = 0; c < NCH; c++) begin
         m_out[c] = '0; m_ren[c] = '0; m_fen[c] = '0; m_stat[c] = '0;
      end
      resetb  = 1'b0;
      gpio_i0 = 16'hFFFF;
      gpio_i1 = 16'h0000;
      m_in    = 16'hFFFF;
      repeat (3) @(negedge clk);
      n_checks++;
      if (gpio_o0 !== 16'h0 || irq0 !== 1'b0 || ready0 !== 1'b0 || rdata0 !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_outputs: gpio_o=%h irq=%b ready=%b rdata=%h, required 0 0 0 0",
                  gpio_o0, irq0, ready0, rdata0);
      end
      resetb = 1'b1;
      // Input reaches IN two cycles after the synchroniser starts sampling.
      for (int k = 1; k <= 3; k++) begin
         bus_xfer(ra(0, 0), 1'b0, 1'b1, 32'h0, q, rdy);
         exp = (k == 3) ? 32'hFF : 32'h0;
         n_checks++;
         if (q !== exp || rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_latency[%0d]: rdata=%h ready=%b, required %h 1", k, q, rdy, exp);
         end
      end
   endtask

   task automatic test_output();
      logic [31:0] q;
      logic        rdy;
      int          ch;
      int          ofs;
      logic [31:0] d;
      logic [7:0]  exp;
      n_checks++;
      if (gpio_o0 !== 16'h0000) begin
         n_fail++;
         $display("FAIL out_before_write: gpio_o=%h, required 0000", gpio_o0);
      end
      bus_xfer(8'h04, 1'b1, 1'b0, 32'hA5, q, rdy);
      m_out[0] = 8'hA5;
      n_checks++;
      if (gpio_o0 !== 16'h00A5 || rdy !== 1'b1 || q !== 32'h0) begin
         n_fail++;
         $display("FAIL out_write_ch0: gpio_o=%h ready=%b rdata=%h, required 00a5 1 0", gpio_o0, rdy, q);
      end
      @(negedge clk);
      n_checks++;
      if (ready0 !== 1'b0) begin
         n_fail++;
         $display("FAIL ready_pulse: ready=%b one cycle later, required 0", ready0);
      end
      bus_xfer(8'h24, 1'b1, 1'b0, 32'h3C, q, rdy);
      m_out[1] = 8'h3C;
      n_checks++;
      if (gpio_o0 !== 16'h3CA5 || rdy !== 1'b1) begin
         n_fail++;
         $display("FAIL out_write_ch1: gpio_o=%h ready=%b, required 3ca5 1", gpio_o0, rdy);
      end
      bus_xfer(8'h04, 1'b0, 1'b1, 32'h0, q, rdy);
      n_checks++;
      if (q !== 32'hA5) begin
         n_fail++;
         $display("FAIL out_readback_ch0: rdata=%h, required 000000a5", q);
      end
      bus_xfer(8'h24, 1'b0, 1'b1, 32'h0, q, rdy);
      n_checks++;
      if (q !== 32'h3C) begin
         n_fail++;
         $display("FAIL out_readback_ch1: rdata=%h, required 0000003c", q);
      end
      // Random writes (upper bits random) then random readbacks, back to back.
      for (int it = 0; it < 10; it++) begin
         ch  = $urandom_range(0, NCH - 1);
         ofs = 4 * $urandom_range(1, 3);
         d   = $urandom;
         bus_xfer(ra(ch, ofs), 1'b1, 1'b0, d, q, rdy);
         if (ofs == 4)      m_out[ch] = d[7:0];
         else if (ofs == 8) m_ren[ch] = d[7:0];
         else               m_fen[ch] = d[7:0];
         ch  = $urandom_range(0, NCH - 1);
         ofs = 4 * $urandom_range(1, 3);
         exp = (ofs == 4) ? m_out[ch] : (ofs == 8) ? m_ren[ch] : m_fen[ch];
         bus_xfer(ra(ch, ofs), 1'b0, 1'b1, 32'h0, q, rdy);
         n_checks++;
         if (q !== {24'h0, exp} || gpio_o0 !== {m_out[1], m_out[0]}) begin
            n_fail++;
            $display("FAIL rand_rw[%0d] ch%0d ofs%0h: rdata=%h gpio_o=%h, required %h %h",
                     it, ch, ofs, q, gpio_o0, exp, {m_out[1], m_out[0]});
         end
      end
      for (int c = 0; c < NCH; c++) begin
         bus_xfer(ra(c, 8), 1'b1, 1'b0, 32'h0, q, rdy);
         bus_xfer(ra(c, 12), 1'b1, 1'b0, 32'h0, q, rdy);
         m_ren[c] = '0;
         m_fen[c] = '0;
      end
   endtask

   task automatic test_rw_same();
      logic [31:0] q;
      logic        rdy;
      logic [7:0]  nv;
      logic [7:0]  old;
      old = m_out[0];
      nv  = 8'($urandom) ^ 8'h5A;
      if (nv == old) nv = ~old;
      bus_xfer(8'h04, 1'b1, 1'b1, {24'h0, nv}, q, rdy);
      m_out[0] = nv;
      n_checks++;
      if (q !== {24'h0, old} || gpio_o0[7:0] !== nv || rdy !== 1'b1) begin
         n_fail++;
         $display("FAIL rw_same_cycle: rdata=%h gpio_o=%h ready=%b, required %h %h 1",
                  q, gpio_o0[7:0], rdy, old, nv);
      end
   endtask

   task automatic test_rise();
      logic [31:0] q;
      logic        rdy;
      int          first;
      gpio_i0 = 16'h00FF;
      m_in    = 16'h00FF;
      repeat (4) @(negedge clk);
      bus_xfer(8'h28, 1'b1, 1'b0, 32'h01, q, rdy);
      m_ren[1] = 8'h01;
      gpio_i0[8] = 1'b1;
      m_in[8]    = 1'b1;
      first = 0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (irq0 === 1'b1 && first == 0) first = k;
      end
      n_checks++;
      if (first != 4) begin
         n_fail++;
         $display("FAIL rise_irq_latency: irq first high after %0d cycles, required 4", first);
      end
      bus_xfer(8'h30, 1'b0, 1'b1, 32'h0, q, rdy);
      n_checks++;
      if (q !== 32'h01) begin
         n_fail++;
         $display("FAIL rise_status: rdata=%h, required 00000001", q);
      end
      bus_xfer(8'h30, 1'b1, 1'b0, 32'h01, q, rdy);
      n_checks++;
      if (irq0 !== 1'b1) begin
         n_fail++;
         $display("FAIL w1c_irq_hold: irq=%b on clear edge, required 1", irq0);
      end
      @(negedge clk);
      n_checks++;
      if (irq0 !== 1'b0) begin
         n_fail++;
         $display("FAIL w1c_irq_clear: irq=%b one cycle after clear, required 0", irq0);
      end
      gpio_i0[8] = 1'b0;
      m_in[8]    = 1'b0;
      repeat (6) @(negedge clk);
      bus_xfer(8'h30, 1'b0, 1'b1, 32'h0, q, rdy);
      n_checks++;
      if (q !== 32'h0 || irq0 !== 1'b0) begin
         n_fail++;
         $display("FAIL fall_not_enabled: status=%h irq=%b, required 0 0", q, irq0);
      end
      // Enabling after the edge must not recover it.
      bus_xfer(8'h2C, 1'b1, 1'b0, 32'h01, q, rdy);
      repeat (2) @(negedge clk);
      bus_xfer(8'h30, 1'b0, 1'b1, 32'h0, q, rdy);
      n_checks++;
      if (q !== 32'h0 || irq0 !== 1'b0) begin
         n_fail++;
         $display("FAIL late_enable: status=%h irq=%b, required 0 0", q, irq0);
      end
      bus_xfer(8'h28, 1'b1, 1'b0, 32'h0, q, rdy);
      bus_xfer(8'h2C, 1'b1, 1'b0, 32'h0, q, rdy);
      m_ren[1] = '0;
      m_fen[1] = '0;
   endtask

   task automatic test_random_edges();
      logic [31:0] q;
      logic        rdy;
      logic [15:0] nv;
      logic [15:0] ov;
      logic [7:0]  r;
      logic [7:0]  f;
      logic [7:0]  mask;
      int          c;
      for (int it = 0; it < 12; it++) begin
         for (int ch = 0; ch < NCH; ch++) begin
            m_ren[ch] = 8'($urandom);
            m_fen[ch] = 8'($urandom);
            bus_xfer(ra(ch, 8), 1'b1, 1'b0, {24'($urandom), m_ren[ch]}, q, rdy);
            bus_xfer(ra(ch, 12), 1'b1, 1'b0, {24'($urandom), m_fen[ch]}, q, rdy);
         end
         ov = m_in;
         nv = 16'($urandom);
         for (int ch = 0; ch < NCH; ch++) begin
            r = nv[ch*8 +: 8] & ~ov[ch*8 +: 8];
            f = ~nv[ch*8 +: 8] & ov[ch*8 +: 8];
            m_stat[ch] = m_stat[ch] | (r & m_ren[ch]) | (f & m_fen[ch]);
         end
         gpio_i0 = nv;
         m_in    = nv;
         repeat (5) @(negedge clk);
         for (int ch = 0; ch < NCH; ch++) begin
            bus_xfer(ra(ch, 16), 1'b0, 1'b1, 32'h0, q, rdy);
            n_checks++;
            if (q !== {24'h0, m_stat[ch]}) begin
               n_fail++;
               $display("FAIL rand_status[%0d] ch%0d: rdata=%h, required %h", it, ch, q, m_stat[ch]);
            end
            bus_xfer(ra(ch, 0), 1'b0, 1'b1, 32'h0, q, rdy);
            n_checks++;
            if (q !== {24'h0, m_in[ch*8 +: 8]}) begin
               n_fail++;
               $display("FAIL rand_in[%0d] ch%0d: rdata=%h, required %h", it, ch, q, m_in[ch*8 +: 8]);
            end
         end
         n_checks++;
         if (irq0 !== m_irq()) begin
            n_fail++;
            $display("FAIL rand_irq[%0d]: irq=%b, required %b", it, irq0, m_irq());
         end
         c    = $urandom_range(0, NCH - 1);
         mask = 8'($urandom);
         bus_xfer(ra(c, 16), 1'b1, 1'b0, {24'hFFFFFF, mask}, q, rdy);
         m_stat[c] = m_stat[c] & ~mask;
         @(negedge clk);
      end
      for (int ch = 0; ch < NCH; ch++) begin
         bus_xfer(ra(ch, 8), 1'b1, 1'b0, 32'h0, q, rdy);
         bus_xfer(ra(ch, 12), 1'b1, 1'b0, 32'h0, q, rdy);
         bus_xfer(ra(ch, 16), 1'b1, 1'b0, 32'hFF, q, rdy);
         m_ren[ch] = '0; m_fen[ch] = '0; m_stat[ch] = '0;
      end
   endtask

   task automatic test_collision();
      logic [31:0] q;
      logic        rdy;
      logic        held;
      gpio_i0 = 16'h0004;
      m_in    = 16'h0004;
      repeat (5) @(negedge clk);
      bus_xfer(8'h0C, 1'b1, 1'b0, 32'h04, q, rdy);
      m_fen[0] = 8'h04;
      gpio_i0[2] = 1'b0;
      repeat (5) @(negedge clk);
      gpio_i0[2] = 1'b1;
      repeat (5) @(negedge clk);
      bus_xfer(8'h10, 1'b0, 1'b1, 32'h0, q, rdy);
      n_checks++;
      if (q !== 32'h04 || irq0 !== 1'b1) begin
         n_fail++;
         $display("FAIL collision_setup: status=%h irq=%b, required 04 1", q, irq0);
      end
      // Second falling edge: status is set on the third edge after the drop,
      // the same edge that carries the W1C strobe.
      gpio_i0[2] = 1'b0;
      m_in       = 16'h0000;
      repeat (2) @(negedge clk);
      bus_xfer(8'h10, 1'b1, 1'b0, 32'h04, q, rdy);
      held = irq0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         held = held & irq0;
      end
      n_checks++;
      if (held !== 1'b1) begin
         n_fail++;
         $display("FAIL collision_irq: irq dropped (held=%b), required 1", held);
      end
      bus_xfer(8'h10, 1'b0, 1'b1, 32'h0, q, rdy);
      n_checks++;
      if (q !== 32'h04) begin
         n_fail++;
         $display("FAIL collision_status: rdata=%h, required 00000004", q);
      end
      bus_xfer(8'h10, 1'b1, 1'b0, 32'h04, q, rdy);
      @(negedge clk);
      bus_xfer(8'h10, 1'b0, 1'b1, 32'h0, q, rdy);
      n_checks++;
      if (q !== 32'h0 || irq0 !== 1'b0) begin
         n_fail++;
         $display("FAIL plain_w1c: status=%h irq=%b, required 0 0", q, irq0);
      end
      bus_xfer(8'h0C, 1'b1, 1'b0, 32'h0, q, rdy);
      m_fen[0] = '0;
   endtask

   task automatic test_unmapped();
      logic [31:0] q;
      logic        rdy;
      bus_xfer(8'h40, 1'b0, 1'b1, 32'h0, q, rdy);
      n_checks++;
      if (q !== 32'h0 || rdy !== 1'b1) begin
         n_fail++;
         $display("FAIL unmapped_read_40: rdata=%h ready=%b, required 0 1", q, rdy);
      end
      bus_xfer(8'h14, 1'b0, 1'b1, 32'h0, q, rdy);
      n_checks++;
      if (q !== 32'h0 || rdy !== 1'b1) begin
         n_fail++;
         $display("FAIL unmapped_read_14: rdata=%h ready=%b, required 0 1", q, rdy);
      end
      bus_xfer(8'h44, 1'b1, 1'b0, 32'hFF, q, rdy);
      bus_xfer(8'h18, 1'b1, 1'b0, 32'hFF, q, rdy);
      n_checks++;
      if (gpio_o0 !== {m_out[1], m_out[0]} || rdy !== 1'b1) begin
         n_fail++;
         $display("FAIL unmapped_write: gpio_o=%h ready=%b, required %h 1",
                  gpio_o0, rdy, {m_out[1], m_out[0]});
      end
   endtask

   task automatic test_debounce();
      logic [31:0] q;
      logic        rdy;
      int          first;
      bus_sel = 1'b1;
      bus_xfer(8'h08, 1'b1, 1'b0, 32'h01, q, rdy);
      gpio_i1[0] = 1'b1;
      repeat (3) @(negedge clk);
      gpio_i1[0] = 1'b0;
      repeat (8) @(negedge clk);
      bus_xfer(8'h00, 1'b0, 1'b1, 32'h0, q, rdy);
      n_checks++;
      if (q !== 32'h0) begin
         n_fail++;
         $display("FAIL deb_glitch_in: rdata=%h, required 0", q);
      end
      bus_xfer(8'h10, 1'b0, 1'b1, 32'h0, q, rdy);
      n_checks++;
      if (q !== 32'h0 || irq1 !== 1'b0) begin
         n_fail++;
         $display("FAIL deb_glitch_status: status=%h irq=%b, required 0 0", q, irq1);
      end
      gpio_i1[0] = 1'b1;
      first = 0;
      for (int k = 1; k <= 9; k++) begin
         bus_xfer(8'h00, 1'b0, 1'b1, 32'h0, q, rdy);
         if (q[0] === 1'b1 && first == 0) first = k;
      end
      n_checks++;
      if (first != 7) begin
         n_fail++;
         $display("FAIL deb_latency: IN first high on read %0d, required 7", first);
      end
      repeat (3) @(negedge clk);
      bus_xfer(8'h10, 1'b0, 1'b1, 32'h0, q, rdy);
      n_checks++;
      if (q !== 32'h01 || irq1 !== 1'b1) begin
         n_fail++;
         $display("FAIL deb_status: status=%h irq=%b, required 01 1", q, irq1);
      end
      gpio_i1[0] = 1'b0;
      repeat (3) @(negedge clk);
      gpio_i1[0] = 1'b1;
      repeat (8) @(negedge clk);
      bus_xfer(8'h00, 1'b0, 1'b1, 32'h0, q, rdy);
      n_checks++;
      if (q !== 32'h01) begin
         n_fail++;
         $display("FAIL deb_low_glitch: rdata=%h, required 01", q);
      end
      bus_sel = 1'b0;
   endtask

   task automatic test_reset_abort();
      logic [31:0] q;
      logic        rdy;
      bus_xfer(8'h04, 1'b1, 1'b0, 32'h5A, q, rdy);
      io_addr = 8'h04;
      io_rd   = 1'b1;
      resetb  = 1'b0;
      #1;
      n_checks++;
      if (gpio_o0 !== 16'h0 || irq1 !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset: gpio_o=%h irq_deb=%b, required 0 0", gpio_o0, irq1);
      end
      @(negedge clk);
      io_rd  = 1'b0;
      resetb = 1'b1;
      @(negedge clk);
      n_checks++;
      if (ready0 !== 1'b0 || rdata0 !== 32'h0) begin
         n_fail++;
         $display("FAIL aborted_ready: ready=%b rdata=%h, required 0 0", ready0, rdata0);
      end
      bus_xfer(8'h04, 1'b0, 1'b1, 32'h0, q, rdy);
      n_checks++;
      if (q !== 32'h0 || rdy !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_cleared_out: rdata=%h ready=%b, required 0 1", q, rdy);
      end
      bus_sel = 1'b1;
      bus_xfer(8'h10, 1'b0, 1'b1, 32'h0, q, rdy);
      n_checks++;
      if (q !== 32'h0 || irq1 !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_cleared_status: status=%h irq=%b, required 0 0", q, irq1);
      end
      bus_sel = 1'b0;
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_output();
      test_rw_same();
      test_rise();
      test_random_edges();
      test_collision();
      test_unmapped();
      test_debounce();
      test_reset_abort();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at 500000, required to finish earlier");
      $fatal(1, "watchdog expired");
   end

endmodule
